// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: routes the WB stage and two long-latency
// writeback sources onto the two RF write ports, with a round-robin pointer, a collision filter and counters.
module rf_write_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [4:0]       req0_reg,
    input  logic [31:0]      req0_data,
    input  logic             req1_valid,
    input  logic [4:0]       req1_reg,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    input  logic             req2_valid,
    input  logic [4:0]       req2_reg,
    input  logic [31:0]      req2_data,
    output logic             req2_ready,
    output logic             RegWrite,
    output logic [4:0]       Write_register,
    output logic [31:0]      Write_data,
    output logic             RegWrite2,
    output logic [4:0]       Write_register2,
    output logic [31:0]      Write_data2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt,
    output logic             err_dup
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_rrPtr;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_squashCnt;
    logic             r_errDup;

    logic        w_v0, w_v1, w_v2;
    logic        w_gnt1, w_gnt2;
    logic        w_aUsed, w_bUsed;
    logic [4:0]  w_aReg, w_bReg;
    logic [31:0] w_aData, w_bData;
    logic        w_collide, w_weA, w_weB, w_stall;

    // Requests are ignored while reset is held so no grant or write can escape.
    assign w_v0 = req0_valid & ~reset;
    assign w_v1 = req1_valid & ~reset;
    assign w_v2 = req2_valid & ~reset;

    always_comb begin
        w_gnt1 = w_v1;
        w_gnt2 = w_v2;
        if (w_v0 && w_v1 && w_v2) begin
            w_gnt1 = ~r_rrPtr;
            w_gnt2 = r_rrPtr;
        end
    end

    always_comb begin
        w_aUsed = 1'b0;
        w_aReg  = 5'd0;
        w_aData = 32'd0;
        w_bUsed = 1'b0;
        w_bReg  = 5'd0;
        w_bData = 32'd0;
        if (w_v0) begin
            w_aUsed = 1'b1;
            w_aReg  = req0_reg;
            w_aData = req0_data;
            if (w_gnt1) begin
                w_bUsed = 1'b1;
                w_bReg  = req1_reg;
                w_bData = req1_data;
            end else if (w_gnt2) begin
                w_bUsed = 1'b1;
                w_bReg  = req2_reg;
                w_bData = req2_data;
            end
        end else if (w_gnt1) begin
            w_aUsed = 1'b1;
            w_aReg  = req1_reg;
            w_aData = req1_data;
            if (w_gnt2) begin
                w_bUsed = 1'b1;
                w_bReg  = req2_reg;
                w_bData = req2_data;
            end
        end else if (w_gnt2) begin
            w_aUsed = 1'b1;
            w_aReg  = req2_reg;
            w_aData = req2_data;
        end
    end

    // Port A always holds the write that survives a same-register collision.
    assign w_collide = w_aUsed & w_bUsed & (w_aReg == w_bReg) & (w_aReg != 5'd0);
    assign w_weA     = w_aUsed & (w_aReg != 5'd0);
    assign w_weB     = w_bUsed & (w_bReg != 5'd0) & ~w_collide;

    assign RegWrite        = w_weA;
    assign Write_register  = w_weA ? w_aReg  : 5'd0;
    assign Write_data      = w_weA ? w_aData : 32'd0;
    assign RegWrite2       = w_weB;
    assign Write_register2 = w_weB ? w_bReg  : 5'd0;
    assign Write_data2     = w_weB ? w_bData : 32'd0;

    assign req1_ready = w_gnt1;
    assign req2_ready = w_gnt2;

    assign w_stall = (req1_valid & ~w_gnt1) | (req2_valid & ~w_gnt2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rrPtr     <= 1'b0;
            r_stallCnt  <= '0;
            r_squashCnt <= '0;
            r_errDup    <= 1'b0;
        end else begin
            // After a contested cycle the pointer favours the source that lost.
            if (w_v1 && w_v2 && (w_gnt1 ^ w_gnt2))
                r_rrPtr <= w_gnt1;
            if (w_stall && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + CntOne;
            if (w_collide && (r_squashCnt != '1))
                r_squashCnt <= r_squashCnt + CntOne;
            if (w_collide && !w_v0)
                r_errDup <= 1'b1;
        end
    end

    assign stall_cnt  = r_stallCnt;
    assign squash_cnt = r_squashCnt;
    assign err_dup    = r_errDup;

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Arbitrates the two register-file write ports (port A = RegWrite/Write_register/Write_data, port B = RegWrite2/Write_register2/Write_data2) among three writeback sources.
- Sources: req0 = main pipeline WB stage (never stalls), req1 = multi-cycle mul/div unit, req2 = load/miss-return unit.
- Sits between the WB stage / long-latency units and the register file.
- Holds the round-robin state, a same-destination collision filter and performance/error counters.

Parameters:
- CNT_W, 16, width of the stall and squash counters (saturating).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  WB-stage write request; always accepted, no ready.
- req0_reg  in  5  destination register.
- req0_data  in  32  write data.
- req1_valid / req2_valid  in  1  long-latency write requests.
- req1_reg / req2_reg  in  5  destination registers.
- req1_data / req2_data  in  32  write data.
- req1_ready / req2_ready  out  1  request accepted this cycle (combinational).
- RegWrite, Write_register, Write_data  out  1/5/32  port A drive.
- RegWrite2, Write_register2, Write_data2  out  1/5/32  port B drive.
- stall_cnt  out  CNT_W  cycles in which any valid req1/req2 saw ready=0.
- squash_cnt  out  CNT_W  requests dropped by the collision filter.
- err_dup  out  1  sticky: req1 and req2 were granted to the same nonzero register in one cycle.

Behaviour:
- Port outputs and readys are combinational from the inputs and the state. Handshake and write complete in the same cycle; the register file commits on the next posedge.
- State:
  - rr_ptr (1 bit): 0 means req1 has priority, 1 means req2 has priority.
  - stall_cnt, squash_cnt, err_dup.
- Reset (synchronous): rr_ptr=0, counters=0, err_dup=0.
- Port outputs carry no state. With all valids low: RegWrite=RegWrite2=0, registers=0, data=0.
- Grant rules per cycle:
  - req0_valid=1: req0 drives port A. The remaining port B goes to the rr winner among valid req1/req2. The loser gets ready=0.
  - req0_valid=0: req1 takes port A and req2 takes port B, if valid. Both readys are 1.
  - Only one of req1/req2 valid: it gets the lowest free port.
- rr_ptr update: toggles only in cycles where req1 and req2 are both valid and only one is granted. It then points to the loser.
- Handshake: req1/req2 hold valid, reg and data stable until ready=1. A transfer is valid&ready. Deasserting valid without ready is illegal and unchecked.
- Register 0: a grant to reg 0 is acknowledged (ready=1) but drives that port's RegWrite=0.
- Collision filter, applied after grant, for two granted writes to the same nonzero register:
  - req0 vs req1/req2: req0 is architecturally youngest and is written. The other is acknowledged (ready=1), squashed (its port RegWrite=0), and squash_cnt increments.
  - req1 vs req2 (req0 idle): an issue violation. req1 (port A) is written, req2 is acked and squashed, squash_cnt increments, err_dup is set.
  - Both ports never assert the same nonzero register in one cycle.
- stall_cnt increments once per cycle when any of (req1_valid&!req1_ready), (req2_valid&!req2_ready) holds.
- Both counters saturate at all-ones.
- err_dup clears only on reset.
- Reset mid-operation: pending requests are ignored that cycle. Readys are 0 while reset=1, and RegWrite=RegWrite2=0.

Test Plan:
1. Reset, then req0 only: req0_valid=1, reg=5, data=0x11 → RegWrite=1, Write_register=5, Write_data=0x11, RegWrite2=0, counters 0.
2. req0, req1 and req2 all valid for 3 cycles (regs 3,4,6) → grant sequence req1, req2, req1 on port B; non-granted ready=0; stall_cnt=3; req0 on port A every cycle.
3. req0_valid=0 with req1(reg 8, 0xA) and req2(reg 9, 0xB) → port A=8/0xA, port B=9/0xB, both ready=1, rr_ptr unchanged, stall_cnt unchanged.
4. req0(reg 7, 0x1) and req1(reg 7, 0x2), req2 idle → only port A writes 7=0x1, RegWrite2=0, req1_ready=1, squash_cnt=1.
5. req1 and req2 both reg 12, req0 idle → port A writes req1 data, RegWrite2=0, err_dup=1 and stays 1 until reset; squash_cnt incremented.
6. req1 to reg 0 → req1_ready=1 with both RegWrite=0; counters preloaded near max saturate at 0xFFFF; asserting reset mid-stall zeros counters and rr_ptr next cycle.
